// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end for the single-cycle MIPS core.
// Holds the fetch PC and issues one word read at a time to a variable-latency
// instruction memory (req/ack). Returned words are buffered with their PCs in a
// DEPTH-entry FIFO that the core drains through a valid/ready handshake. A
// redirect flushes the FIFO and restarts fetch at a new address. An ack for a
// request that was in flight when the redirect arrived is swallowed.
//
// Build option: define FETCH_BYPASS_EN so that a word returning into an empty
// FIFO is presented to the core in the same cycle. Without it, all core-facing
// outputs come from registers and have a one-cycle fill latency.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  // Fetch sequencing state
  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic        mem_req_reg;
  logic [31:0] mem_addr_reg;

  // FIFO storage (no reset: contents are only meaningful below count)
  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] word_mem [DEPTH];

  // FIFO bookkeeping and registered head
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic             valid_reg;
  logic [31:0]      head_pc_reg,   head_pc_next;
  logic [31:0]      head_word_reg, head_word_next;

  logic [31:0]      redirect_aligned;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic             ack_wait;
  logic             space_ok;
  logic             pop_fifo;
  logic             bypass_hit;
  logic             bypass_take;
  logic             push;

  // The two low address bits of a redirect target are dropped by design.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign rd_ptr_inc       = rd_ptr_reg + PTR_W'(1);
  assign ack_wait         = (state_reg == S_WAIT) && mem_ack;
  assign space_ok         = count_reg < CNT_W'(DEPTH);

  // A redirect voids any pop in the same cycle: the head is being thrown away.
  assign pop_fifo = valid_reg && inst_ready && !redirect;

`ifdef FETCH_BYPASS_EN
  // Word arriving into an empty FIFO is shown to the core immediately; if the
  // core takes it this cycle it never enters the FIFO.
  assign bypass_hit  = (count_reg == '0) && ack_wait && !redirect;
  assign bypass_take = bypass_hit && inst_ready;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // Only an ack for a live (non-discarded, non-redirected) request is stored.
  assign push = ack_wait && !redirect && !bypass_take;

  // Next-state for FIFO pointers, occupancy and the registered head entry
  always_comb begin
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    head_pc_next   = head_pc_reg;
    head_word_next = head_word_reg;
    if (redirect) begin
      rd_ptr_next    = '0;
      wr_ptr_next    = '0;
      count_next     = '0;
      head_pc_next   = '0;
      head_word_next = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop_fifo) begin
        rd_ptr_next = rd_ptr_inc;
      end
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop_fifo);
      if (pop_fifo) begin
        if (count_reg > CNT_W'(1)) begin
          // Following entry is already in storage.
          head_pc_next   = pc_mem[rd_ptr_inc];
          head_word_next = word_mem[rd_ptr_inc];
        end else if (push) begin
          // Last entry leaves while a new one arrives: it becomes the head.
          head_pc_next   = fetch_pc_reg;
          head_word_next = mem_rdata;
        end
      end else if (push && (count_reg == '0)) begin
        head_pc_next   = fetch_pc_reg;
        head_word_next = mem_rdata;
      end
    end
  end

  // Write returned words into FIFO storage at the tail
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= fetch_pc_reg;
      word_mem[wr_ptr_reg] <= mem_rdata;
    end
  end

  // Register FIFO pointers, occupancy and head outputs
  always_ff @(posedge clock) begin
    if (!Reset) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      valid_reg     <= 1'b0;
      head_pc_reg   <= '0;
      head_word_reg <= '0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      valid_reg     <= (count_next != '0);
      head_pc_reg   <= head_pc_next;
      head_word_reg <= head_word_next;
    end
  end

  // Fetch FSM: one outstanding request, request/address held until ack
  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_PC;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= RESET_PC;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (redirect) begin
            fetch_pc_reg <= redirect_aligned;
          end else if (space_ok) begin
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= fetch_pc_reg;
            state_reg    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            fetch_pc_reg <= redirect_aligned;
            if (mem_ack) begin
              // Data returned in the redirect cycle is simply dropped.
              mem_req_reg <= 1'b0;
              state_reg   <= S_IDLE;
            end else begin
              // Request must still complete on the bus; its data is junk now.
              state_reg <= S_DISCARD;
            end
          end else if (mem_ack) begin
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
            mem_req_reg  <= 1'b0;
            state_reg    <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (redirect) begin
            fetch_pc_reg <= redirect_aligned;
          end
          if (mem_ack) begin
            mem_req_reg <= 1'b0;
            state_reg   <= S_IDLE;
          end
        end
        default: begin
          mem_req_reg <= 1'b0;
          state_reg   <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_reg;
  assign mem_addr = mem_addr_reg;

  assign inst_valid  = valid_reg || bypass_hit;
  assign instruction = bypass_hit ? mem_rdata    : head_word_reg;
  assign inst_pc     = bypass_hit ? fetch_pc_reg : head_pc_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue. A cycle-stepped memory model
// answers each request after a programmable latency with word = address. Every
// issued request and every consumed instruction is printed on one line.
module tb_fetch_queue;

  logic        clock = 1'b0;
  logic        Reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;

  // Memory model controls
  bit mem_en;
  int mem_lat;
  int req_age;

  logic [31:0] req_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_inst_log[$];

  fetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clock(clock),
    .Reset(Reset),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .inst_valid(inst_valid),
    .instruction(instruction),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic clear_logs();
    req_log.delete();
    pop_pc_log.delete();
    pop_inst_log.delete();
  endtask

  // One clock: log the pop the DUT is about to take, cross the edge, then
  // update the memory model for the next edge.
  task automatic step();
    if (Reset && inst_valid && inst_ready && !redirect) begin
      pop_pc_log.push_back(inst_pc);
      pop_inst_log.push_back(instruction);
      $display("pop  pc=%h inst=%h", inst_pc, instruction);
    end
    @(posedge clock);
    #1;
    if (mem_req) begin
      req_age++;
      if (req_age == 1) begin
        req_log.push_back(mem_addr);
        $display("req  addr=%h", mem_addr);
      end
    end else begin
      req_age = 0;
    end
    if (mem_en && mem_req && req_age >= mem_lat) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_addr;
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    Reset      = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b0;
    steps(2);
    Reset = 1'b1;
  endtask

  initial begin
    Reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    inst_ready  = 1'b0;
    mem_en      = 1'b0;
    mem_lat     = 1;
    req_age     = 0;

    // Reset state
    steps(2);
    check_value("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_value("rst_mem_addr", mem_addr, 32'h0);
    check_value("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check_value("rst_instruction", instruction, 32'h0);
    check_value("rst_inst_pc", inst_pc, 32'h0);

    // 1-cycle memory, core always ready: streaming fetch from 0
    mem_en = 1'b1;
    mem_lat = 1;
    clear_logs();
    Reset = 1'b1;
    inst_ready = 1'b1;
    step();
    check_value("t1_first_req", {31'b0, mem_req}, 32'd1);
    check_value("t1_first_addr", mem_addr, 32'h0);
    steps(12);
    check_value("t1_req0", qget(req_log, 0), 32'h0);
    check_value("t1_req1", qget(req_log, 1), 32'h4);
    check_value("t1_req2", qget(req_log, 2), 32'h8);
    check_value("t1_pop_cnt_ge3", {31'b0, pop_pc_log.size() >= 3}, 32'd1);
    check_value("t1_pc0", qget(pop_pc_log, 0), 32'h0);
    check_value("t1_pc1", qget(pop_pc_log, 1), 32'h4);
    check_value("t1_pc2", qget(pop_pc_log, 2), 32'h8);
    check_value("t1_inst0", qget(pop_inst_log, 0), 32'h0);
    check_value("t1_inst1", qget(pop_inst_log, 1), 32'h4);
    check_value("t1_inst2", qget(pop_inst_log, 2), 32'h8);

    // Core stalled: FIFO fills with exactly 4 words, then fetch stops
    do_reset();
    clear_logs();
    mem_lat = 1;
    steps(20);
    check_value("t2_nreq_full", 32'(req_log.size()), 32'd4);
    check_value("t2_req_low", {31'b0, mem_req}, 32'd0);
    check_value("t2_valid", {31'b0, inst_valid}, 32'd1);
    check_value("t2_head_pc", inst_pc, 32'h0);
    check_value("t2_req3", qget(req_log, 3), 32'hC);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    steps(5);
    check_value("t2_nreq_after_pop", 32'(req_log.size()), 32'd5);
    check_value("t2_req4", qget(req_log, 4), 32'h10);
    check_value("t2_npop", 32'(pop_pc_log.size()), 32'd1);
    check_value("t2_head_pc_after", inst_pc, 32'h4);

    // Redirect in IDLE with 3 entries buffered (target low bits ignored)
    inst_ready = 1'b1;
    step();
    inst_ready  = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check_value("t3_valid_flushed", {31'b0, inst_valid}, 32'd0);
    check_value("t3_no_req", {31'b0, mem_req}, 32'd0);
    step();
    check_value("t3_req", {31'b0, mem_req}, 32'd1);
    check_value("t3_addr", mem_addr, 32'h0000_0100);
    steps(4);
    check_value("t3_valid", {31'b0, inst_valid}, 32'd1);
    check_value("t3_head_pc", inst_pc, 32'h0000_0100);
    check_value("t3_head_inst", instruction, 32'h0000_0100);

    // Redirect while waiting on a slow read of 0x8
    do_reset();
    clear_logs();
    mem_lat = 5;
    inst_ready = 1'b1;
    begin
      int n = 0;
      while (!(mem_req && mem_addr == 32'h8) && n < 200) begin
        step();
        n++;
      end
      check_value("t4_saw_req8", {31'b0, mem_req && mem_addr == 32'h8}, 32'd1);
    end
    clear_logs();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    begin
      bit hold_ok = 1'b1;
      int n = 0;
      while (mem_req && n < 20) begin
        if (mem_addr !== 32'h8) hold_ok = 1'b0;
        step();
        n++;
      end
      check_value("t4_addr_held", {31'b0, hold_ok}, 32'd1);
      check_value("t4_discard_done", {31'b0, mem_req}, 32'd0);
    end
    steps(20);
    check_value("t4_req0", qget(req_log, 0), 32'h200);
    check_value("t4_pc0", qget(pop_pc_log, 0), 32'h200);
    check_value("t4_inst0", qget(pop_inst_log, 0), 32'h200);
    check_value("t4_pc1", qget(pop_pc_log, 1), 32'h204);

    // Redirect to the top word: fetch wraps to 0
    do_reset();
    clear_logs();
    mem_lat     = 1;
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    steps(12);
    check_value("t5_req0", qget(req_log, 0), 32'hFFFF_FFFC);
    check_value("t5_req1", qget(req_log, 1), 32'h0);
    check_value("t5_npop_ge2", {31'b0, pop_pc_log.size() >= 2}, 32'd1);
    check_value("t5_pc0", qget(pop_pc_log, 0), 32'hFFFF_FFFC);
    check_value("t5_inst0", qget(pop_inst_log, 0), 32'hFFFF_FFFC);
    check_value("t5_pc1", qget(pop_pc_log, 1), 32'h0);

    // Reset asserted mid-WAIT, then a stale ack
    do_reset();
    clear_logs();
    mem_lat = 2;
    begin
      int n = 0;
      while (req_log.size() < 2 && n < 50) begin
        step();
        n++;
      end
      check_value("t6_second_req", 32'(req_log.size()), 32'd2);
    end
    check_value("t6_pre_valid", {31'b0, inst_valid}, 32'd1);
    mem_en  = 1'b0;
    mem_ack = 1'b0;
    Reset   = 1'b0;
    step();
    check_value("t6_rst_req", {31'b0, mem_req}, 32'd0);
    check_value("t6_rst_addr", mem_addr, 32'h0);
    check_value("t6_rst_valid", {31'b0, inst_valid}, 32'd0);
    check_value("t6_rst_inst", instruction, 32'h0);
    check_value("t6_rst_pc", inst_pc, 32'h0);
    Reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    check_value("t6_stale_valid", {31'b0, inst_valid}, 32'd0);
    check_value("t6_new_req", {31'b0, mem_req}, 32'd1);
    check_value("t6_new_addr", mem_addr, 32'h0);
    steps(3);
    check_value("t6_still_empty", {31'b0, inst_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
